// File: rtl/ball_renderer.sv
// Shades VGA pixels as ball fill, outline or background in a fixed 3-stage pipeline.
// The ball position is snapshotted once per frame on the VS rising edge, so frames never tear.
module ball_renderer #(
    parameter logic [23:0] BALL_RGB = 24'hFF5500,
    parameter logic [23:0] EDGE_RGB = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB   = 24'h00003F,
    parameter logic [9:0]  RST_X    = 10'd320,
    parameter logic [9:0]  RST_Y    = 10'd240,
    parameter logic [9:0]  RST_S    = 10'd4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       VS,
    input  logic       pixel_valid,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] BallX,
    input  logic [9:0] BallY,
    input  logic [9:0] BallS,
    output logic [7:0] Red,
    output logic [7:0] Green,
    output logic [7:0] Blue,
    output logic       out_valid,
    output logic [7:0] frame_count
);

    logic              vs_d;
    logic              snap;
    logic [9:0]        sh_x;
    logic [9:0]        sh_y;
    logic [9:0]        sh_s;

    logic signed [10:0] dx_p1;
    logic signed [10:0] dy_p1;
    logic [19:0]        r2_p1;
    logic [19:0]        ri2_p1;
    logic               zero_p1;
    logic               vld_p1;

    logic [20:0]        d2_p2;
    logic [19:0]        r2_p2;
    logic [19:0]        ri2_p2;
    logic               zero_p2;
    logic               vld_p2;

    function automatic logic [19:0] sq10(input logic [9:0] a);
        return {10'd0, a} * {10'd0, a};
    endfunction

    // Squares via the magnitude; |dx| <= 1023, so the result fits 20 bits of a 21-bit word.
    function automatic logic [20:0] sq11(input logic signed [10:0] a);
        logic [10:0] m;
        m = a[10] ? -a : a;
        return {10'd0, m} * {10'd0, m};
    endfunction

    function automatic logic [23:0] shade(input logic vld, input logic zero,
                                          input logic [20:0] d2, input logic [19:0] ri2,
                                          input logic [19:0] r2);
        if (!vld)                  return 24'd0;
        else if (zero)             return BG_RGB;
        else if (d2 <= {1'b0, ri2}) return BALL_RGB;
        else if (d2 <= {1'b0, r2})  return EDGE_RGB;
        else                       return BG_RGB;
    endfunction

    assign snap = VS & ~vs_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vs_d        <= 1'b1;
            sh_x        <= RST_X;
            sh_y        <= RST_Y;
            sh_s        <= RST_S;
            frame_count <= 8'd0;
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            out_valid   <= 1'b0;
            {Red, Green, Blue} <= 24'd0;
        end else begin
            vs_d <= VS;
            if (snap) begin
                sh_x        <= BallX;
                sh_y        <= BallY;
                sh_s        <= BallS;
                frame_count <= frame_count + 8'd1;
            end
            vld_p1    <= pixel_valid;
            vld_p2    <= vld_p1;
            out_valid <= vld_p2;
            {Red, Green, Blue} <= shade(vld_p2, zero_p2, d2_p2, ri2_p2, r2_p2);
        end
    end

    // Stage 1: offsets from the shadow centre; the shadow read here is the pre-snap value.
    always_ff @(posedge Clk) begin
        dx_p1   <= $signed({1'b0, DrawX}) - $signed({1'b0, sh_x});
        dy_p1   <= $signed({1'b0, DrawY}) - $signed({1'b0, sh_y});
        r2_p1   <= sq10(sh_s);
        ri2_p1  <= (sh_s == 10'd0) ? 20'd0 : sq10(sh_s - 10'd1);
        zero_p1 <= (sh_s == 10'd0);
    end

    // Stage 2: squared distance; radii and zero-size flag ride along so a snap cannot affect them.
    always_ff @(posedge Clk) begin
        d2_p2   <= sq11(dx_p1) + sq11(dy_p1);
        r2_p2   <= r2_p1;
        ri2_p2  <= ri2_p1;
        zero_p2 <= zero_p1;
    end

endmodule

// File: tb/tb_ball_renderer.sv
// Directed and randomized checks of ball_renderer against a cycle-level reference model.
module tb_ball_renderer;

    localparam logic [23:0] BALL = 24'hFF5500;
    localparam logic [23:0] EDGE = 24'hFFFFFF;
    localparam logic [23:0] BG   = 24'h00003F;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       VS;
    logic       pixel_valid;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [9:0] BallX;
    logic [9:0] BallY;
    logic [9:0] BallS;
    logic [7:0] Red;
    logic [7:0] Green;
    logic [7:0] Blue;
    logic       out_valid;
    logic [7:0] frame_count;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          msx, msy, mss;
    int          mfc;
    logic        mvsd;
    logic        e1_v, e2_v, eo_v;
    logic [23:0] e1_c, e2_c, eo_c;
    int          valid_seen;

    ball_renderer dut (
        .Clk(Clk), .Reset(Reset), .VS(VS), .pixel_valid(pixel_valid),
        .DrawX(DrawX), .DrawY(DrawY), .BallX(BallX), .BallY(BallY), .BallS(BallS),
        .Red(Red), .Green(Green), .Blue(Blue), .out_valid(out_valid),
        .frame_count(frame_count)
    );

    always #5 Clk = ~Clk;

    function automatic logic [23:0] shade_ref(input int x, input int y, input int sx,
                                              input int sy, input int ss);
        int d2;
        d2 = (x - sx) * (x - sx) + (y - sy) * (y - sy);
        if (ss == 0)                       return BG;
        else if (d2 <= (ss - 1) * (ss - 1)) return BALL;
        else if (d2 <= ss * ss)             return EDGE;
        else                               return BG;
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, compare outputs.
    task automatic tick(input logic rst, input logic vs, input logic pv,
                        input logic [9:0] x, input logic [9:0] y);
        logic        nv;
        logic [23:0] nc;
        Reset = rst; VS = vs; pixel_valid = pv; DrawX = x; DrawY = y;
        nv = pv;
        nc = pv ? shade_ref(int'(x), int'(y), msx, msy, mss) : 24'd0;
        @(posedge Clk);
        if (rst) begin
            msx = 320; msy = 240; mss = 4; mfc = 0; mvsd = 1'b1;
            e1_v = 0; e2_v = 0; eo_v = 0; e1_c = 0; e2_c = 0; eo_c = 0;
        end else begin
            if (vs && !mvsd) begin
                msx = int'(BallX); msy = int'(BallY); mss = int'(BallS);
                mfc = (mfc + 1) % 256;
            end
            mvsd = vs;
            eo_v = e2_v; eo_c = e2_c;
            e2_v = e1_v; e2_c = e1_c;
            e1_v = nv;   e1_c = nc;
        end
        #1;
        if (out_valid === 1'b1) valid_seen++;
        chk("model_valid", {23'd0, out_valid}, {23'd0, eo_v});
        chk("model_rgb", {Red, Green, Blue}, eo_c);
        chk("model_fc", {16'd0, frame_count}, mfc[23:0]);
    endtask

    task automatic idle();
        tick(1'b0, VS, 1'b0, 10'd0, 10'd0);
    endtask

    // Pixel, then two idle cycles, leaves that pixel on the outputs.
    task automatic pix_check(input logic [9:0] x, input logic [9:0] y,
                             input logic [23:0] exp, input string tag);
        tick(1'b0, VS, 1'b1, x, y);
        idle();
        idle();
        chk(tag, {Red, Green, Blue}, exp);
        chk({tag, "_valid"}, {23'd0, out_valid}, 24'd1);
    endtask

    initial begin
        int x, y, r;
        logic vs_now;
        msx = 320; msy = 240; mss = 4; mfc = 0; mvsd = 1'b1;
        e1_v = 0; e2_v = 0; eo_v = 0; e1_c = 0; e2_c = 0; eo_c = 0;
        valid_seen = 0;
        BallX = 10'd320; BallY = 10'd240; BallS = 10'd4;
        VS = 1'b1;

        tick(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
        tick(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
        chk("reset_rgb", {Red, Green, Blue}, 24'd0);
        chk("reset_valid", {23'd0, out_valid}, 24'd0);
        chk("reset_fc", {16'd0, frame_count}, 24'd0);

        pix_check(10'd320, 10'd240, BALL, "centre_fill");
        pix_check(10'd324, 10'd240, EDGE, "rim_edge");
        pix_check(10'd325, 10'd240, BG,   "outside_bg");
        tick(1'b0, 1'b1, 1'b1, 10'd323, 10'd243);
        idle(); idle();

        BallX = 10'd100; BallY = 10'd50; BallS = 10'd8;
        tick(1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
        tick(1'b0, 1'b1, 1'b0, 10'd0, 10'd0);
        chk("latch_fc", {16'd0, frame_count}, 24'd1);
        pix_check(10'd100, 10'd50, BALL, "latched_fill");
        pix_check(10'd320, 10'd240, BG, "old_pos_bg");

        BallX = 10'd500;
        pix_check(10'd100, 10'd50, BALL, "no_tear");

        BallX = 10'd600;
        tick(1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
        tick(1'b0, 1'b1, 1'b1, 10'd100, 10'd50);
        tick(1'b0, 1'b1, 1'b1, 10'd100, 10'd50);
        idle();
        chk("collide_old", {Red, Green, Blue}, BALL);
        idle();
        chk("collide_new", {Red, Green, Blue}, BG);

        tick(1'b0, 1'b1, 1'b0, 10'd600, 10'd50);
        idle(); idle();
        chk("blank_rgb", {Red, Green, Blue}, 24'd0);
        chk("blank_valid", {23'd0, out_valid}, 24'd0);

        // radius 1 near the right margin
        BallX = 10'd1020; BallY = 10'd10; BallS = 10'd1;
        tick(1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
        tick(1'b0, 1'b1, 1'b0, 10'd0, 10'd0);
        pix_check(10'd1020, 10'd10, BALL, "r1_centre");
        pix_check(10'd1021, 10'd10, EDGE, "r1_neigh");
        pix_check(10'd1021, 10'd11, BG,   "r1_diag");
        pix_check(10'd0,    10'd10, BG,   "far_left");

        BallS = 10'd0;
        tick(1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
        tick(1'b0, 1'b1, 1'b0, 10'd0, 10'd0);
        pix_check(10'd1020, 10'd10, BG, "zero_size");

        tick(1'b0, 1'b1, 1'b1, 10'd1, 10'd1);
        tick(1'b0, 1'b1, 1'b1, 10'd2, 10'd2);
        tick(1'b0, 1'b1, 1'b1, 10'd3, 10'd3);
        valid_seen = 0;
        tick(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
        idle(); idle(); idle();
        chk("flush_valids", valid_seen[23:0], 24'd0);

        for (int i = 0; i < 256; i++) begin
            tick(1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
            tick(1'b0, 1'b1, 1'b0, 10'd0, 10'd0);
        end
        chk("fc_wrap", {16'd0, frame_count}, 24'd0);

        BallX = 10'd200; BallY = 10'd200; BallS = 10'd5;
        tick(1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
        tick(1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
        tick(1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
        tick(1'b0, 1'b1, 1'b0, 10'd0, 10'd0);
        chk("vs_low_reset_fc", {16'd0, frame_count}, 24'd1);
        pix_check(10'd200, 10'd200, BALL, "vs_low_reset_fill");

        vs_now = 1'b1;
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 12) begin
                BallX = 10'($urandom_range(0, 1023));
                BallY = 10'($urandom_range(0, 1023));
                BallS = 10'($urandom_range(0, 12));
            end
            if (r % 9 == 0) vs_now = ~vs_now;
            x = msx + int'($urandom_range(0, 2 * mss + 4)) - mss - 2;
            y = msy + int'($urandom_range(0, 2 * mss + 4)) - mss - 2;
            tick(r < 2, vs_now, $urandom_range(0, 3) != 0, x[9:0], y[9:0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
